// File: rtl/ltl_report_collector.sv
// -----------------------------------------------------------------------------
// ltl_report_collector
//
// Collects the per-cycle report wires of a generated LTL automaton, stamps
// every non-zero report vector with the index of the symbol that caused it,
// and buffers the stamped events in a FIFO drained over a valid/ready stream
// toward the cluster-level monitor aggregator.
//
// The automaton registers its active state. The reports visible in cycle t+1
// therefore belong to the symbol consumed in cycle t. The collector delays the
// run strobe and the symbol index by one cycle (run_q / idx_q) to line them up
// with the reports.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-low; clears all state
//   run             high when the automaton consumes one symbol this cycle
//   clear           synchronous soft clear, active-high; same effect as reset
//   reports         automaton report wires, concatenated in report-index order
//   out_valid       FIFO head valid (decoded from registered level)
//   out_ready       consumer accepts the head when out_valid && out_ready
//   out_data        {timestamp, report vector}, timestamp in the MSBs
//   sticky_reports  OR of every captured report vector since reset/clear
//   overflow        sticky; set when a capture is dropped on a full FIFO
//   drop_count      number of dropped captures, saturating at all-ones
//   fifo_level      current FIFO occupancy
// -----------------------------------------------------------------------------
module ltl_report_collector #(
   parameter int NUM_REPORTS = 4,
   parameter int TS_W        = 32,
   parameter int DEPTH       = 8,
   parameter int DROP_W      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run,
   input  logic                          clear,
   input  logic [NUM_REPORTS-1:0]        reports,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [TS_W+NUM_REPORTS-1:0]   out_data,
   output logic [NUM_REPORTS-1:0]        sticky_reports,
   output logic                          overflow,
   output logic [DROP_W-1:0]             drop_count,
   output logic [$clog2(DEPTH):0]        fifo_level
);

   localparam int AW      = $clog2(DEPTH);
   localparam int ENTRY_W = TS_W + NUM_REPORTS;

   localparam logic [AW:0]       PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0]       LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]       WRAP_ONE = {1'b1, {AW{1'b0}}};
   localparam logic [TS_W-1:0]   TS_ONE   = TS_W'(1);
   localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   // Symbol indexing and one-cycle alignment with the automaton's reports.
   logic [TS_W-1:0]  sym_idx;
   logic [TS_W-1:0]  idx_q;
   logic             run_q;

   // FIFO storage and pointers. Each pointer carries one extra wrap bit so
   // that full is distinguishable from empty when the address bits match.
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;

   logic soft_rst;
   logic capture;
   logic full;
   logic pop;
   logic push;
   logic drop;

   // Reset and clear are handled identically; folding them keeps a single
   // clearing path for every register.
   assign soft_rst = !reset || clear;

   // NOTE: every signal written in always_comb gets a default assignment
   // first, so no path through the block can leave it unassigned and infer a
   // latch.
   always_comb begin
      capture = 1'b0;
      full    = 1'b0;
      pop     = 1'b0;
      push    = 1'b0;
      drop    = 1'b0;

      // Reports only count when the previous cycle consumed a symbol.
      capture = run_q && (|reports);
      full    = (wr_ptr ^ rd_ptr) == WRAP_ONE;
      pop     = out_valid && out_ready;
      // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
      push    = capture && (!full || pop);
      drop    = capture && full && !pop;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its peers regardless of the
   // order in which the statements appear.
   always_ff @(posedge clk) begin
      if (soft_rst) begin
         sym_idx        <= '0;
         idx_q          <= '0;
         run_q          <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_level     <= '0;
         sticky_reports <= '0;
         overflow       <= 1'b0;
         drop_count     <= '0;
      end else begin
         // Free-running symbol counter; wraps naturally at 2^TS_W.
         if (run) begin
            sym_idx <= sym_idx + TS_ONE;
         end
         run_q <= run;
         idx_q <= sym_idx;

         // Sticky flags record every capture attempt, including dropped ones.
         if (capture) begin
            sticky_reports <= sticky_reports | reports;
         end

         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         unique case ({push, pop})
            2'b10:   fifo_level <= fifo_level + PTR_ONE;
            2'b01:   fifo_level <= fifo_level - PTR_ONE;
            default: fifo_level <= fifo_level;
         endcase

         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != DROP_MAX) begin
               drop_count <= drop_count + DROP_ONE;
            end
         end
      end
   end

   // NOTE: the storage array is deliberately not reset. Only the pointers
   // define which entries are live, and leaving the array out of reset lets
   // it map onto plain RAM; out_data is masked to zero while empty instead.
   always_ff @(posedge clk) begin
      if (push && !soft_rst) begin
         mem[wr_ptr[AW-1:0]] <= {idx_q, reports};
      end
   end

   // Head of the FIFO, decoded from registered state only.
   assign out_valid = (fifo_level != '0);
   assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

   // The level register and the pointer difference describe the same
   // occupancy; LVL_FULL documents the upper bound of fifo_level.
   logic unused_lvl_full;
   assign unused_lvl_full = (fifo_level == LVL_FULL);

endmodule

// File: tb/tb_ltl_report_collector.sv
// -----------------------------------------------------------------------------
// tb_ltl_report_collector
//
// Directed bench for ltl_report_collector. A 32-bit timestamp instance covers
// capture, gating, backpressure, overflow, push/pop at full, saturation and
// mid-stream reset/clear. A 4-bit timestamp instance shares the same inputs
// and is used for the timestamp wrap case.
//
// Timing convention: inputs change 1 time unit after a rising edge and the
// outputs are sampled at that same point, i.e. they show the state produced
// by the edge just passed.
// -----------------------------------------------------------------------------
module tb_ltl_report_collector;

   logic        clk;
   logic        reset;
   logic        run;
   logic        clear;
   logic [3:0]  reports;
   logic        out_ready;

   logic        out_valid;
   logic [35:0] out_data;
   logic [3:0]  sticky_reports;
   logic        overflow;
   logic [7:0]  drop_count;
   logic [3:0]  fifo_level;

   logic        w_valid;
   logic [7:0]  w_data;
   logic [3:0]  w_sticky;
   logic        w_overflow;
   logic [7:0]  w_drop;
   logic [3:0]  w_level;

   int n_checks = 0;
   int n_errors = 0;

   ltl_report_collector #(
      .NUM_REPORTS(4), .TS_W(32), .DEPTH(8), .DROP_W(8)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .clear(clear), .reports(reports),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sticky_reports(sticky_reports), .overflow(overflow),
      .drop_count(drop_count), .fifo_level(fifo_level)
   );

   ltl_report_collector #(
      .NUM_REPORTS(4), .TS_W(4), .DEPTH(8), .DROP_W(8)
   ) dut_w (
      .clk(clk), .reset(reset), .run(run), .clear(clear), .reports(reports),
      .out_valid(w_valid), .out_ready(out_ready), .out_data(w_data),
      .sticky_reports(w_sticky), .overflow(w_overflow),
      .drop_count(w_drop), .fifo_level(w_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        run;
      logic [3:0]  rep;
      logic        ready;
      logic        exp_valid;
      logic [35:0] exp_data;
      logic [3:0]  exp_level;
      logic [3:0]  exp_sticky;
      logic        exp_ovf;
      logic [7:0]  exp_drop;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      clear     = 1'b0;
      run       = 1'b0;
      reports   = 4'h0;
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic drive(input logic r, input logic [3:0] rep, input logic rdy);
      run       = r;
      reports   = rep;
      out_ready = rdy;
   endtask

   // Fill with 10 captures (8 kept, 2 dropped), drain 5, leaving 3 entries,
   // then hit the block with clear or reset while a capture is pending.
   task automatic mid_stream(input bit use_reset);
      string tag;
      tag = use_reset ? "rst" : "clr";
      do_reset();
      drive(1'b1, 4'h0, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 4'h1, 1'b0);
         tick();
      end
      drive(1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      drive(1'b1, 4'h0, 1'b0);
      tick();
      check({tag, "_pre_level"}, fifo_level, 4'd3);
      check({tag, "_pre_ovf"}, overflow, 1'b1);

      drive(1'b1, 4'h1, 1'b0);
      if (use_reset) reset = 1'b0;
      else           clear = 1'b1;
      tick();
      reset = 1'b1;
      clear = 1'b0;
      check({tag, "_level"},  fifo_level,     4'd0);
      check({tag, "_valid"},  out_valid,      1'b0);
      check({tag, "_data"},   out_data,       36'h0);
      check({tag, "_ovf"},    overflow,       1'b0);
      check({tag, "_sticky"}, sticky_reports, 4'h0);
      check({tag, "_drop"},   drop_count,     8'd0);

      // First symbol after the clear must be stamped 0.
      drive(1'b1, 4'h0, 1'b0);
      tick();
      drive(1'b0, 4'h2, 1'b0);
      tick();
      drive(1'b0, 4'h0, 1'b0);
      check({tag, "_next_level"}, fifo_level, 4'd1);
      check({tag, "_next_data"},  out_data,   {32'd0, 4'h2});
   endtask

   initial begin
      // ---------------------------------------------------------------
      // Basic capture and run gating, table driven.
      // ---------------------------------------------------------------
      vecs[0] = '{1'b1, 4'h0, 1'b1, 1'b0, 36'h0,          4'd0, 4'h0, 1'b0, 8'd0};
      vecs[1] = '{1'b1, 4'h0, 1'b1, 1'b0, 36'h0,          4'd0, 4'h0, 1'b0, 8'd0};
      vecs[2] = '{1'b1, 4'h0, 1'b1, 1'b0, 36'h0,          4'd0, 4'h0, 1'b0, 8'd0};
      vecs[3] = '{1'b1, 4'h2, 1'b1, 1'b1, {32'd2, 4'h2},  4'd1, 4'h2, 1'b0, 8'd0};
      vecs[4] = '{1'b1, 4'h0, 1'b1, 1'b0, 36'h0,          4'd0, 4'h2, 1'b0, 8'd0};
      vecs[5] = '{1'b0, 4'h0, 1'b1, 1'b0, 36'h0,          4'd0, 4'h2, 1'b0, 8'd0};
      vecs[6] = '{1'b0, 4'hF, 1'b1, 1'b0, 36'h0,          4'd0, 4'h2, 1'b0, 8'd0};
      vecs[7] = '{1'b1, 4'hF, 1'b1, 1'b0, 36'h0,          4'd0, 4'h2, 1'b0, 8'd0};
      vecs[8] = '{1'b0, 4'h0, 1'b1, 1'b0, 36'h0,          4'd0, 4'h2, 1'b0, 8'd0};

      do_reset();
      check("rst_valid",  out_valid,      1'b0);
      check("rst_data",   out_data,       36'h0);
      check("rst_sticky", sticky_reports, 4'h0);
      check("rst_ovf",    overflow,       1'b0);
      check("rst_drop",   drop_count,     8'd0);
      check("rst_level",  fifo_level,     4'd0);

      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].run, vecs[i].rep, vecs[i].ready);
         tick();
         check($sformatf("vec%0d_valid", i),  out_valid,      vecs[i].exp_valid);
         check($sformatf("vec%0d_data", i),   out_data,       vecs[i].exp_data);
         check($sformatf("vec%0d_level", i),  fifo_level,     vecs[i].exp_level);
         check($sformatf("vec%0d_sticky", i), sticky_reports, vecs[i].exp_sticky);
         check($sformatf("vec%0d_ovf", i),    overflow,       vecs[i].exp_ovf);
         check($sformatf("vec%0d_drop", i),   drop_count,     vecs[i].exp_drop);
      end

      // ---------------------------------------------------------------
      // Backpressure: 10 captures into 8 slots, then drain in order.
      // ---------------------------------------------------------------
      do_reset();
      drive(1'b1, 4'h0, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 4'h1, 1'b0);
         tick();
      end
      drive(1'b0, 4'h0, 1'b0);
      check("bp_level",  fifo_level,     4'd8);
      check("bp_ovf",    overflow,       1'b1);
      check("bp_drop",   drop_count,     8'd2);
      check("bp_sticky", sticky_reports, 4'h1);
      tick();
      check("bp_hold_data", out_data, {32'd0, 4'h1});
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bp_beat%0d_valid", i), out_valid, 1'b1);
         check($sformatf("bp_beat%0d_data", i),  out_data,  {32'(i), 4'h1});
         tick();
      end
      check("bp_empty_valid", out_valid,  1'b0);
      check("bp_empty_level", fifo_level, 4'd0);
      check("bp_drop_hold",   drop_count, 8'd2);

      // ---------------------------------------------------------------
      // Push and pop together while full.
      // ---------------------------------------------------------------
      do_reset();
      drive(1'b1, 4'h0, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'h1, 1'b0);
         tick();
      end
      check("pp_full_level", fifo_level, 4'd8);
      drive(1'b1, 4'h8, 1'b1);
      tick();
      drive(1'b0, 4'h0, 1'b1);
      check("pp_level", fifo_level, 4'd8);
      check("pp_drop",  drop_count, 8'd0);
      check("pp_ovf",   overflow,   1'b0);
      check("pp_head",  out_data,   {32'd1, 4'h1});
      for (int i = 0; i < 7; i++) tick();
      check("pp_last_data",  out_data,       {32'd8, 4'h8});
      check("pp_last_level", fifo_level,     4'd1);
      check("pp_sticky",     sticky_reports, 4'h9);
      tick();
      check("pp_empty", out_valid, 1'b0);

      // Drop counter saturation: 299 captures, 8 stored, 291 dropped.
      drive(1'b1, 4'h1, 1'b0);
      for (int i = 0; i < 300; i++) tick();
      drive(1'b0, 4'h0, 1'b0);
      check("sat_drop",  drop_count, 8'd255);
      check("sat_level", fifo_level, 4'd8);

      // ---------------------------------------------------------------
      // Timestamp wrap on the 4-bit instance.
      // ---------------------------------------------------------------
      do_reset();
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, (k == 16) ? 4'h4 : 4'h0, 1'b0);
         tick();
      end
      drive(1'b0, 4'h4, 1'b0);
      tick();
      drive(1'b0, 4'h0, 1'b0);
      check("wrap_level", w_level, 4'd2);
      check("wrap_ts15",  w_data,  {4'd15, 4'h4});
      out_ready = 1'b1;
      tick();
      check("wrap_ts0",   w_data,  {4'd0, 4'h4});
      tick();
      check("wrap_empty", w_valid, 1'b0);

      // ---------------------------------------------------------------
      // Mid-stream clear, then the same with reset.
      // ---------------------------------------------------------------
      mid_stream(1'b0);
      mid_stream(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
